// File: rtl/adam_periph_uart_pkg.sv
// Shared types and helpers for the ADAM UART receive path.
package adam_periph_uart_pkg;

    localparam int unsigned MAX_DATA_LENGTH = 9;
    localparam int unsigned LEN_W           = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    typedef struct packed {
        logic [MAX_DATA_LENGTH-1:0] data;
        logic                       err_parity;
        logic                       err_frame;
    } rx_entry_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Out-of-range lengths fall back to 8 data bits.
    function automatic logic [LEN_W-1:0] legal_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(MAX_DATA_LENGTH)) begin
            return LEN_W'(8);
        end
        return len;
    endfunction

endpackage

// File: rtl/adam_periph_uart_rx_fifo.sv
// Synchronous FIFO of received entries with valid/ready head and occupancy output.
module adam_periph_uart_rx_fifo
    import adam_periph_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  rx_entry_t              push_entry,
    input  logic                   pop,
    output rx_entry_t              head,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    rx_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic             push_ok;

    always_comb begin
        level   = wr_q - rd_q;
        valid   = (level != '0);
        full    = (level == PW'(DEPTH));
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_ok = push & (~full | pop);
        wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
        rd_d    = (pop & valid) ? rd_q + PW'(1) : rd_q;
        head    = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_ok) begin
                mem_q[wr_q[AW-1:0]] <= push_entry;
            end
        end
    end

endmodule

// File: rtl/adam_periph_uart_rx_buf.sv
// Buffered UART receiver: majority-voted sampling, parity/framing status, RX FIFO, pause handshake.
// Define ADAM_UART_RX_BREAK_EN to detect line breaks (adds break_det output) instead of pushing them.
module adam_periph_uart_rx_buf
    import adam_periph_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          pause_req,
    output logic                          pause_ack,
    input  logic                          parity_select,
    input  logic                          parity_control,
    input  logic [3:0]                    data_length,
    input  logic [1:0]                    stop_bits,
    input  logic [DATA_WIDTH-1:0]         baud_rate,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_overrun,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef ADAM_UART_RX_BREAK_EN
    ,
    output logic                          break_det
`endif
);

    rx_state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]     sync_q, sync_d;
    logic [1:0]                 hist_q, hist_d;
    logic [DATA_WIDTH-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      baud_q, baud_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           idx_q, idx_d;
    logic [1:0]                 stop_q, stop_d;
    logic                       par_ctrl_q, par_ctrl_d;
    logic                       par_sel_q, par_sel_d;
    logic [MAX_DATA_LENGTH-1:0] shift_q, shift_d;
    logic                       par_acc_q, par_acc_d;
    logic                       par_err_q, par_err_d;
    logic                       ferr_q, ferr_d;
    logic                       pause_ack_q, pause_ack_d;
    logic                       ovr_q, ovr_d;
`ifdef ADAM_UART_RX_BREAK_EN
    logic                       ones_q, ones_d;
    logic                       brk_q, brk_d;
`endif

    logic      rx_s, maj, start_edge, bit_done;
    logic      push, pop, fifo_valid, fifo_full;
    rx_entry_t push_entry, head;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    // Vote over the current synced sample and the two before it.
    assign maj        = maj3(hist_q[1], hist_q[0], rx_s);
    assign start_edge = hist_q[0] & ~rx_s;
    assign bit_done   = (cnt_q == baud_q - DATA_WIDTH'(1));
    assign data_valid = fifo_valid & ~pause_ack_q;
    assign pop        = data_valid & data_ready;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
        hist_d      = {hist_q[0], rx_s};
        state_d     = state_q;
        cnt_d       = cnt_q + DATA_WIDTH'(1);
        baud_d      = baud_q;
        len_d       = len_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        par_ctrl_d  = par_ctrl_q;
        par_sel_d   = par_sel_q;
        shift_d     = shift_q;
        par_acc_d   = par_acc_q;
        par_err_d   = par_err_q;
        ferr_d      = ferr_q;
        pause_ack_d = pause_ack_q;
        push        = 1'b0;
        push_entry  = '{data: shift_q, err_parity: par_ctrl_q & par_err_q, err_frame: ferr_q | ~maj};
`ifdef ADAM_UART_RX_BREAK_EN
        brk_d       = brk_q;
        ones_d      = ones_q;
        if (state_q == IDLE) begin
            ones_d = 1'b0;
        end else if ((state_q == DATA || state_q == PARITY || state_q == STOP) && bit_done) begin
            ones_d = ones_q | maj;
        end
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pause_ack_q) begin
                    if (!pause_req) begin
                        pause_ack_d = 1'b0;
                    end
                end else if (pause_req) begin
                    pause_ack_d = 1'b1;
                end else if (start_edge && baud_rate >= DATA_WIDTH'(4)) begin
                    state_d    = START;
                    baud_d     = baud_rate;
                    len_d      = legal_len(data_length);
                    stop_d     = stop_bits;
                    par_ctrl_d = parity_control;
                    par_sel_d  = parity_select;
                    idx_d      = '0;
                    shift_d    = '0;
                    par_acc_d  = 1'b0;
                    par_err_d  = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            START: begin
                if (cnt_q == (baud_q >> 1)) begin
                    cnt_d   = '0;
                    state_d = maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    par_acc_d = par_acc_q ^ maj;
                    for (int unsigned i = 0; i < MAX_DATA_LENGTH; i++) begin
                        if (idx_q == LEN_W'(i)) begin
                            shift_d[i] = maj;
                        end
                    end
                    if (idx_q == len_q - LEN_W'(1)) begin
                        idx_d   = '0;
                        state_d = par_ctrl_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    par_err_d = ((par_acc_q ^ par_sel_q) != maj);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~maj;
                    if (idx_q == LEN_W'(stop_q)) begin
                        idx_d   = '0;
                        state_d = IDLE;
`ifdef ADAM_UART_RX_BREAK_EN
                        if (!ones_q && !maj) begin
                            state_d = BREAK;
                            brk_d   = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
`ifdef ADAM_UART_RX_BREAK_EN
            // Leave only after one full bit time of uninterrupted idle line.
            BREAK: begin
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (bit_done) begin
                    state_d = IDLE;
                    brk_d   = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new overrun takes priority over a coincident clear.
        if (push && fifo_full && !pop) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            hist_q      <= '1;
            cnt_q       <= '0;
            baud_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            stop_q      <= '0;
            par_ctrl_q  <= 1'b0;
            par_sel_q   <= 1'b0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
            ferr_q      <= 1'b0;
            pause_ack_q <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef ADAM_UART_RX_BREAK_EN
            ones_q      <= 1'b0;
            brk_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            baud_q      <= baud_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            par_ctrl_q  <= par_ctrl_d;
            par_sel_q   <= par_sel_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            par_err_q   <= par_err_d;
            ferr_q      <= ferr_d;
            pause_ack_q <= pause_ack_d;
            ovr_q       <= ovr_d;
`ifdef ADAM_UART_RX_BREAK_EN
            ones_q      <= ones_d;
            brk_q       <= brk_d;
`endif
        end
    end

    adam_periph_uart_rx_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .valid      (fifo_valid),
        .full       (fifo_full),
        .level      (fifo_level)
    );

    assign pause_ack   = pause_ack_q;
    assign data        = DATA_WIDTH'(head.data);
    assign err_parity  = head.err_parity;
    assign err_frame   = head.err_frame;
    assign err_overrun = ovr_q;
`ifdef ADAM_UART_RX_BREAK_EN
    assign break_det   = brk_q;
`endif

endmodule

// File: tb/tb_adam_periph_uart_rx_buf.sv
// Directed self-checking bench for adam_periph_uart_rx_buf (honours ADAM_UART_RX_BREAK_EN).
module tb_adam_periph_uart_rx_buf;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    typedef logic [DW+1:0] word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          pause_req;
    logic          pause_ack;
    logic          parity_select;
    logic          parity_control;
    logic [3:0]    data_length;
    logic [1:0]    stop_bits;
    logic [DW-1:0] baud_rate;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          data_ready;
    logic          err_parity;
    logic          err_frame;
    logic          err_overrun;
    logic          overrun_clr;
    logic [LW-1:0] fifo_level;
`ifdef ADAM_UART_RX_BREAK_EN
    logic          break_det;
`endif

    int    checks   = 0;
    int    failures = 0;
    int    tb_baud  = 16;
    word_t rxq[$];

    adam_periph_uart_rx_buf #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx             (rx),
        .pause_req      (pause_req),
        .pause_ack      (pause_ack),
        .parity_select  (parity_select),
        .parity_control (parity_control),
        .data_length    (data_length),
        .stop_bits      (stop_bits),
        .baud_rate      (baud_rate),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .err_parity     (err_parity),
        .err_frame      (err_frame),
        .err_overrun    (err_overrun),
        .overrun_clr    (overrun_clr),
        .fifo_level     (fifo_level)
`ifdef ADAM_UART_RX_BREAK_EN
        ,
        .break_det      (break_det)
`endif
    );

    always #5 clk = ~clk;

    // Record every accepted word; data_ready only changes just after a rising edge.
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) rxq.push_back({data, err_parity, err_frame});
    end

    function automatic word_t exp_w(input logic [8:0] d, input logic ep, input logic ef);
        return {23'd0, d, ep, ef};
    endfunction

    function automatic word_t pop_w();
        if (rxq.size() == 0) return 'x;
        return rxq.pop_front();
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 data_ready = v;
    endtask

    task automatic set_baud(input int b);
        tb_baud   = b;
        baud_rate = DW'(b);
    endtask

    task automatic wait_rx(input int n);
        for (int k = 0; k < 4000 && rxq.size() < n; k++) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (tb_baud) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input bit par_en,
                              input logic par_bit, input int nstop, input logic stop_val);
        @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (par_en) send_bit(par_bit);
        for (int i = 0; i < nstop; i++) send_bit(stop_val);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx = 1'b1; pause_req = 1'b0; parity_select = 1'b0; parity_control = 1'b0;
        data_length = 4'd8; stop_bits = 2'd0; data_ready = 1'b0; overrun_clr = 1'b0;
        set_baud(16);
        idle(3);
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        checks++; if (fifo_level !== '0) begin failures++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (err_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", err_overrun); end
        checks++; if (pause_ack !== 1'b0) begin failures++; $display("FAIL reset_pause_ack: got %b want 0", pause_ack); end
        checks++; if ({data, err_parity, err_frame} !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", {data, err_parity, err_frame}); end
        rst_n = 1'b1;
        idle(4);
        checks++; if (fifo_level !== '0 || data_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle: level %0d valid %b want 0 0", fifo_level, data_valid); end
    endtask

    task automatic test_8n1_sweep;
        word_t w;
        set_baud(8);
        set_ready(1'b1);
        for (int i = 0; i < 256; i++) send_frame(9'(i), 8, 1'b0, 1'b0, 1, 1'b1);
        wait_rx(256);
        checks++; if (rxq.size() != 256) begin failures++; $display("FAIL sweep_count: got %0d want 256", rxq.size()); end
        for (int i = 0; i < 256; i++) begin
            w = pop_w();
            checks++; if (w !== exp_w(9'(i), 1'b0, 1'b0)) begin failures++; $display("FAIL sweep_word%0d: got %h want %h", i, w, exp_w(9'(i), 1'b0, 1'b0)); end
        end
        set_baud(16);
    endtask

    task automatic test_parity;
        word_t w;
        rxq.delete();
        parity_control = 1'b1; parity_select = 1'b0;
        send_frame(9'h059, 8, 1'b1, 1'b0, 1, 1'b1);
        send_frame(9'h05A, 8, 1'b1, 1'b1, 1, 1'b1);
        send_frame(9'h05B, 8, 1'b1, 1'b1, 1, 1'b1);
        parity_select = 1'b1;
        send_frame(9'h001, 8, 1'b1, 1'b0, 1, 1'b1);
        send_frame(9'h001, 8, 1'b1, 1'b1, 1, 1'b1);
        wait_rx(5);
        w = pop_w(); checks++; if (w !== exp_w(9'h059, 1'b0, 1'b0)) begin failures++; $display("FAIL parity_even_ok0: got %h want %h", w, exp_w(9'h059, 1'b0, 1'b0)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h05A, 1'b1, 1'b0)) begin failures++; $display("FAIL parity_even_bad: got %h want %h", w, exp_w(9'h05A, 1'b1, 1'b0)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h05B, 1'b0, 1'b0)) begin failures++; $display("FAIL parity_even_ok1: got %h want %h", w, exp_w(9'h05B, 1'b0, 1'b0)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h001, 1'b0, 1'b0)) begin failures++; $display("FAIL parity_odd_ok: got %h want %h", w, exp_w(9'h001, 1'b0, 1'b0)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h001, 1'b1, 1'b0)) begin failures++; $display("FAIL parity_odd_bad: got %h want %h", w, exp_w(9'h001, 1'b1, 1'b0)); end
        parity_control = 1'b0; parity_select = 1'b0;
    endtask

    task automatic test_overrun;
        word_t w;
        rxq.delete();
        set_ready(1'b0);
        for (int i = 0; i < DEPTH + 2; i++) send_frame(9'(8'h10 + i), 8, 1'b0, 1'b0, 1, 1'b1);
        idle(10);
        checks++; if (fifo_level !== LW'(DEPTH)) begin failures++; $display("FAIL overrun_level: got %0d want %0d", fifo_level, DEPTH); end
        checks++; if (err_overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b want 1", err_overrun); end
        checks++; if (data_valid !== 1'b1 || data !== DW'(8'h10)) begin failures++; $display("FAIL overrun_head_hold: valid %b data %h want 1 10", data_valid, data); end
        overrun_clr = 1'b1; idle(1); overrun_clr = 1'b0; idle(1);
        checks++; if (err_overrun !== 1'b0) begin failures++; $display("FAIL overrun_clr: got %b want 0", err_overrun); end
        set_ready(1'b1);
        wait_rx(DEPTH);
        idle(4);
        checks++; if (rxq.size() != DEPTH) begin failures++; $display("FAIL overrun_count: got %0d want %0d", rxq.size(), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            w = pop_w();
            checks++; if (w !== exp_w(9'(8'h10 + i), 1'b0, 1'b0)) begin failures++; $display("FAIL overrun_word%0d: got %h want %h", i, w, exp_w(9'(8'h10 + i), 1'b0, 1'b0)); end
        end
        checks++; if (fifo_level !== '0) begin failures++; $display("FAIL overrun_drained: got %0d want 0", fifo_level); end
    endtask

    task automatic test_glitch_frame_err;
        word_t w;
        rxq.delete();
        set_baud(32);
        @(negedge clk); rx = 1'b0;
        idle(10);
        rx = 1'b1;
        idle(100);
        checks++; if (fifo_level !== '0 || rxq.size() != 0) begin failures++; $display("FAIL glitch_push: level %0d words %0d want 0 0", fifo_level, rxq.size()); end
        send_frame(9'h033, 8, 1'b0, 1'b0, 1, 1'b0);
        send_bit(1'b1);
        send_frame(9'h034, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_rx(2);
        w = pop_w(); checks++; if (w !== exp_w(9'h033, 1'b0, 1'b1)) begin failures++; $display("FAIL frame_err: got %h want %h", w, exp_w(9'h033, 1'b0, 1'b1)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h034, 1'b0, 1'b0)) begin failures++; $display("FAIL frame_resync: got %h want %h", w, exp_w(9'h034, 1'b0, 1'b0)); end
        set_baud(16);
    endtask

    task automatic test_pause;
        word_t w;
        rxq.delete();
        fork
            send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                idle(60);
                pause_req = 1'b1;
                idle(5);
                checks++; if (pause_ack !== 1'b0) begin failures++; $display("FAIL pause_midframe: got %b want 0", pause_ack); end
            end
        join
        idle(5);
        checks++; if (pause_ack !== 1'b1) begin failures++; $display("FAIL pause_ack_after_frame: got %b want 1", pause_ack); end
        wait_rx(1);
        w = pop_w(); checks++; if (w !== exp_w(9'h0A5, 1'b0, 1'b0)) begin failures++; $display("FAIL pause_word: got %h want %h", w, exp_w(9'h0A5, 1'b0, 1'b0)); end
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(20);
        checks++; if (rxq.size() != 0 || fifo_level !== '0) begin failures++; $display("FAIL paused_rx_ignored: words %0d level %0d want 0 0", rxq.size(), fifo_level); end
        checks++; if (pause_ack !== 1'b1) begin failures++; $display("FAIL pause_ack_hold: got %b want 1", pause_ack); end
        pause_req = 1'b0;
        idle(2);
        checks++; if (pause_ack !== 1'b0) begin failures++; $display("FAIL pause_release: got %b want 0", pause_ack); end
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_rx(1);
        w = pop_w(); checks++; if (w !== exp_w(9'h0C3, 1'b0, 1'b0)) begin failures++; $display("FAIL pause_resume_word: got %h want %h", w, exp_w(9'h0C3, 1'b0, 1'b0)); end
    endtask

    task automatic test_config;
        word_t w;
        rxq.delete();
        data_length = 4'd5; stop_bits = 2'd1;
        send_frame(9'h015, 5, 1'b0, 1'b0, 2, 1'b1);
        data_length = 4'd0; stop_bits = 2'd0;
        send_frame(9'h0C9, 8, 1'b0, 1'b0, 1, 1'b1);
        data_length = 4'd9;
        send_frame(9'h1A5, 9, 1'b0, 1'b0, 1, 1'b1);
        data_length = 4'd12;
        send_frame(9'h06E, 8, 1'b0, 1'b0, 1, 1'b1);
        data_length = 4'd8;
        fork
            send_frame(9'h081, 8, 1'b0, 1'b0, 1, 1'b1);
            begin idle(40); data_length = 4'd4; end
        join
        data_length = 4'd8;
        wait_rx(5);
        w = pop_w(); checks++; if (w !== exp_w(9'h015, 1'b0, 1'b0)) begin failures++; $display("FAIL len5_stop2: got %h want %h", w, exp_w(9'h015, 1'b0, 1'b0)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h0C9, 1'b0, 1'b0)) begin failures++; $display("FAIL len0_as8: got %h want %h", w, exp_w(9'h0C9, 1'b0, 1'b0)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h1A5, 1'b0, 1'b0)) begin failures++; $display("FAIL len9: got %h want %h", w, exp_w(9'h1A5, 1'b0, 1'b0)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h06E, 1'b0, 1'b0)) begin failures++; $display("FAIL len12_as8: got %h want %h", w, exp_w(9'h06E, 1'b0, 1'b0)); end
        w = pop_w(); checks++; if (w !== exp_w(9'h081, 1'b0, 1'b0)) begin failures++; $display("FAIL cfg_frozen: got %h want %h", w, exp_w(9'h081, 1'b0, 1'b0)); end
        set_baud(3);
        @(negedge clk); rx = 1'b0;
        idle(30);
        rx = 1'b1;
        idle(30);
        checks++; if (rxq.size() != 0 || fifo_level !== '0) begin failures++; $display("FAIL slow_baud_ignored: words %0d level %0d want 0 0", rxq.size(), fifo_level); end
        set_baud(16);
        idle(4);
    endtask

`ifdef ADAM_UART_RX_BREAK_EN
    task automatic test_break;
        word_t w;
        rxq.delete();
        @(negedge clk); rx = 1'b0;
        idle(20 * tb_baud);
        checks++; if (break_det !== 1'b1) begin failures++; $display("FAIL break_set: got %b want 1", break_det); end
        checks++; if (fifo_level !== '0 || rxq.size() != 0) begin failures++; $display("FAIL break_no_push: level %0d words %0d want 0 0", fifo_level, rxq.size()); end
        rx = 1'b1;
        idle(8);
        checks++; if (break_det !== 1'b1) begin failures++; $display("FAIL break_hold: got %b want 1", break_det); end
        idle(20);
        checks++; if (break_det !== 1'b0) begin failures++; $display("FAIL break_clear: got %b want 0", break_det); end
        send_frame(9'h05C, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_rx(1);
        w = pop_w(); checks++; if (w !== exp_w(9'h05C, 1'b0, 1'b0)) begin failures++; $display("FAIL break_recover: got %h want %h", w, exp_w(9'h05C, 1'b0, 1'b0)); end
    endtask
`else
    task automatic test_break;
        word_t w;
        rxq.delete();
        send_frame(9'h000, 8, 1'b0, 1'b0, 1, 1'b0);
        send_bit(1'b1);
        wait_rx(1);
        w = pop_w(); checks++; if (w !== exp_w(9'h000, 1'b0, 1'b1)) begin failures++; $display("FAIL break_as_word: got %h want %h", w, exp_w(9'h000, 1'b0, 1'b1)); end
    endtask
`endif

    task automatic test_reset_midframe;
        word_t w;
        rxq.delete();
        set_ready(1'b0);
        send_frame(9'h077, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        checks++; if (fifo_level !== LW'(1)) begin failures++; $display("FAIL pre_reset_level: got %0d want 1", fifo_level); end
        fork
            send_frame(9'h078, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                idle(50);
                rst_n = 1'b0;
                idle(3);
                checks++; if (fifo_level !== '0 || data_valid !== 1'b0) begin failures++; $display("FAIL midframe_reset_flush: level %0d valid %b want 0 0", fifo_level, data_valid); end
                idle(150);
                rst_n = 1'b1;
            end
        join
        idle(20);
        send_frame(9'h079, 8, 1'b0, 1'b0, 1, 1'b1);
        set_ready(1'b1);
        wait_rx(1);
        idle(10);
        checks++; if (rxq.size() != 1) begin failures++; $display("FAIL post_reset_count: got %0d want 1", rxq.size()); end
        w = pop_w(); checks++; if (w !== exp_w(9'h079, 1'b0, 1'b0)) begin failures++; $display("FAIL post_reset_word: got %h want %h", w, exp_w(9'h079, 1'b0, 1'b0)); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1_sweep();
        test_parity();
        test_overrun();
        test_glitch_frame_err();
        test_pause();
        test_config();
        test_break();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
